mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single shared memory bus of the 5-stage MIPS pipeline: grants the bus to the IF stage (instruction fetch) or the MEM stage (load/store). Each access runs as a request/ack transaction. The block produces per-stage stall signals so the hazard unit can freeze the pipeline while an access is outstanding. Fetches are discarded on a branch/jump flush, and an unanswered bus cycle is terminated by a timeout.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mem_port_arbiter_bus_timer.sv | 28 ++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and default widths for the MIPS pipeline memory-port logic.
package mips_pkg;

  localparam int MIPS_ADDR_W = 32;
  localparam int MIPS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_bus_timer.sv
// Bus-cycle watchdog: counts busy cycles without ack and flags the final one.
module bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory-bus arbiter for the IF and MEM stages: fixed MEM priority,
// request/ack sequencing, fetch discard on flush and a bus timeout.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = MIPS_ADDR_W,
  parameter int DATA_W  = MIPS_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_err
);

  arb_state_t        state, state_nxt;
  logic              mem_grant, if_grant, done, expired, discard;
  logic [DATA_W-1:0] done_data;

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    mem_grant = 1'b0;
    if_grant  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // A requester's own ready cycle is skipped: it is still holding req.
        if (mem_req && !mem_ready) begin
          mem_grant = 1'b1;
          state_nxt = MEM_BUSY;
        end else if (if_req && !if_flush && !if_ready) begin
          if_grant  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (bus_ack || expired) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A real ack wins over an expiry landing in the same cycle.
  assign done_data = bus_ack ? bus_rdata : '0;
  assign bus_req   = (state != IDLE);
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;

  bus_timer #(.TIMEOUT(TIMEOUT)) u_bus_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (bus_req && !bus_ack),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      discard   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;

      if (mem_grant) begin
        bus_we    <= mem_we;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
        bus_wstrb <= mem_wstrb;
      end else if (if_grant) begin
        bus_we    <= 1'b0;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        bus_wstrb <= '0;
      end

      if (state_nxt == IDLE) begin
        discard <= 1'b0;
      end else if (state == IF_BUSY && if_flush) begin
        discard <= 1'b1;
      end

      if (done && !bus_ack) begin
        bus_err <= 1'b1;
      end

      if (done && state == MEM_BUSY) begin
        mem_ready <= 1'b1;
        if (!bus_we) begin
          mem_rdata <= done_data;
        end
      end

      // A fetch flushed at any point, including its ack cycle, is dropped.
      if (done && state == IF_BUSY && !discard && !if_flush) begin
        if_ready <= 1'b1;
        if_rdata <= done_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam int NONE  = 0;
  localparam int FETCH = 1;
  localparam int LSU   = 2;

  logic          clk = 1'b0;
  logic          rst, if_req, if_flush, mem_req, mem_we, bus_ack;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, bus_rdata;
  logic [3:0]    mem_wstrb;
  logic          if_ready, mem_ready, stall_if, stall_mem, bus_req, bus_we, bus_err;
  logic [DW-1:0] if_rdata, mem_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one outstanding transaction record plus visible results.
  typedef struct {
    int            owner;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    int            age;
    bit            dropped;
  } txn_t;

  txn_t          m_txn;
  bit            m_if_ready, m_mem_ready, m_err;
  logic [DW-1:0] m_if_rdata, m_mem_rdata;

  // Bus responder: 0 never ack, 1 ack after ack_delay busy cycles, 2 random, 3 always.
  int            resp_mode = 0;
  int            ack_delay = 1;
  logic [DW-1:0] fixed_rdata = '0;
  int            busy_cnt = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_txn       = '{owner: NONE, addr: '0, we: 1'b0, wdata: '0, wstrb: '0, age: 0, dropped: 1'b0};
    m_if_ready  = 1'b0;
    m_mem_ready = 1'b0;
    m_err       = 1'b0;
    m_if_rdata  = '0;
    m_mem_rdata = '0;
  endtask

  // Advance the model across one clock edge using the inputs seen before it.
  task automatic model_step();
    logic [DW-1:0] d;
    bit            nxt_if, nxt_mem;
    nxt_if  = 1'b0;
    nxt_mem = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_txn.owner == NONE) begin
      if (mem_req && !m_mem_ready)
        m_txn = '{owner: LSU, addr: mem_addr, we: mem_we, wdata: mem_wdata,
                  wstrb: mem_wstrb, age: 0, dropped: 1'b0};
      else if (if_req && !if_flush && !m_if_ready)
        m_txn = '{owner: FETCH, addr: if_addr, we: 1'b0, wdata: '0,
                  wstrb: '0, age: 0, dropped: 1'b0};
    end else if (bus_ack || m_txn.age == TO - 1) begin
      d = bus_ack ? bus_rdata : '0;
      if (!bus_ack) m_err = 1'b1;
      if (m_txn.owner == LSU) begin
        nxt_mem = 1'b1;
        if (!m_txn.we) m_mem_rdata = d;
      end else if (!m_txn.dropped && !if_flush) begin
        nxt_if     = 1'b1;
        m_if_rdata = d;
      end
      m_txn.owner = NONE;
    end else begin
      m_txn.age++;
      if (m_txn.owner == FETCH && if_flush) m_txn.dropped = 1'b1;
    end
    m_if_ready  = nxt_if;
    m_mem_ready = nxt_mem;
  endtask

  task automatic check_outputs();
    check("bus_req",   64'(bus_req),   64'(m_txn.owner != NONE));
    check("if_ready",  64'(if_ready),  64'(m_if_ready));
    check("mem_ready", 64'(mem_ready), 64'(m_mem_ready));
    check("if_rdata",  64'(if_rdata),  64'(m_if_rdata));
    check("mem_rdata", 64'(mem_rdata), 64'(m_mem_rdata));
    check("bus_err",   64'(bus_err),   64'(m_err));
    check("stall_if",  64'(stall_if),  64'(if_req && !m_if_ready));
    check("stall_mem", 64'(stall_mem), 64'(mem_req && !m_mem_ready));
    if (m_txn.owner != NONE) begin
      check("bus_addr", 64'(bus_addr), 64'(m_txn.addr));
      check("bus_we",   64'(bus_we),   64'(m_txn.we));
      if (m_txn.owner == LSU) begin
        check("bus_wdata", 64'(bus_wdata), 64'(m_txn.wdata));
        check("bus_wstrb", 64'(bus_wstrb), 64'(m_txn.wstrb));
      end
    end
  endtask

  // One clock cycle: drive the bus response, compare, then cross the edge.
  task automatic tick();
    case (resp_mode)
      1: begin
        bus_ack   = bus_req && (busy_cnt == ack_delay);
        bus_rdata = fixed_rdata;
      end
      2: begin
        bus_ack   = ($urandom_range(0, 2) == 0);
        bus_rdata = $urandom;
      end
      3: bus_ack = 1'b1;
      default: bus_ack = 1'b0;
    endcase
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    busy_cnt = bus_req ? busy_cnt + 1 : -1;
  endtask

  // which: 0 if_ready, 1 mem_ready, 2 bus_req
  task automatic wait_for(input int which, input int limit, output int cycles);
    cycles = 0;
    while (!(which == 0 ? if_ready : (which == 1 ? mem_ready : bus_req)) && cycles < limit) begin
      tick();
      cycles++;
    end
    check("wait_bound", 64'(cycles < limit), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  got;
    bit  prev_if_ready, prev_mem_ready;

    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    @(posedge clk);
    #1;
    model_reset();
    tick();
    rst = 1'b0;
    check("rst_bus_addr",  64'(bus_addr),  64'(0));
    check("rst_bus_wdata", 64'(bus_wdata), 64'(0));
    check("rst_bus_wstrb", 64'(bus_wstrb), 64'(0));
    check("rst_bus_we",    64'(bus_we),    64'(0));

    // Single fetch, ack one cycle after bus_req rises.
    resp_mode = 1; ack_delay = 1; fixed_rdata = 32'h2008_0005;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    wait_for(0, 20, c);
    check("fetch_latency", 64'(c), 64'(3));
    check("fetch_data", 64'(if_rdata), 64'(32'h2008_0005));
    tick();
    if_req = 1'b0;
    tick();

    // Simultaneous load and fetch: MEM first, IF granted in MEM's ready cycle.
    fixed_rdata = 32'h1234_5678;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1000_0000;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    tick();
    check("arb_mem_first", 64'(bus_addr), 64'(32'h1000_0000));
    wait_for(1, 20, c);
    check("load_latency", 64'(c), 64'(2));
    tick();
    mem_req = 1'b0;
    check("if_after_mem_req",  64'(bus_req),  64'(1));
    check("if_after_mem_addr", 64'(bus_addr), 64'(32'h0000_0044));
    wait_for(0, 20, c);
    tick();
    if_req = 1'b0;
    tick();

    // Store with ack after three busy cycles; load data must be untouched.
    ack_delay = 3; fixed_rdata = 32'hFFFF_0000;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1000_0004;
    mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b0011;
    wait_for(1, 20, c);
    check("store_latency", 64'(c), 64'(5));
    check("store_keeps_rdata", 64'(mem_rdata), 64'(32'h1234_5678));
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    tick();

    // Flush two cycles into IF_BUSY, ack at cycle 5: fetch dropped, refetch follows.
    ack_delay = 4; fixed_rdata = 32'hBAD0_BAD0;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got |= if_ready;
    end
    if_flush = 1'b1; if_addr = 32'h0000_0200;
    tick();
    got |= if_ready;
    if_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      got |= if_ready;
    end
    check("flush_no_ready", 64'(got), 64'(0));
    check("flush_keeps_rdata", 64'(if_rdata), 64'(32'h1234_5678));
    fixed_rdata = 32'h00A0_0001;
    wait_for(0, 20, c);
    check("refetch_data", 64'(if_rdata), 64'(32'h00A0_0001));
    tick();
    if_req = 1'b0;
    tick();

    // Bus never answers: timeout completion with zero data and sticky error.
    resp_mode = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0020;
    wait_for(2, 10, c);
    wait_for(1, 20, c);
    check("timeout_latency", 64'(c), 64'(TO));
    check("timeout_err", 64'(bus_err), 64'(1));
    check("timeout_rdata", 64'(mem_rdata), 64'(0));
    tick();
    mem_req = 1'b0;
    repeat (3) tick();
    check("err_sticky", 64'(bus_err), 64'(1));

    // Reset in the middle of a MEM access, then a late ack.
    mem_req = 1'b1; mem_addr = 32'h0000_0030;
    tick();
    tick();
    rst = 1'b1; mem_req = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_bus_req", 64'(bus_req), 64'(0));
    check("rst_mid_err", 64'(bus_err), 64'(0));
    check("rst_mid_addr", 64'(bus_addr), 64'(0));
    resp_mode = 3;
    tick();
    resp_mode = 0;
    check("late_ack_no_ready", 64'(mem_ready), 64'(0));
    tick();

    // Random traffic with held requests, flushes, random acks and rare resets.
    resp_mode = 2;
    prev_if_ready = 1'b0;
    prev_mem_ready = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!if_req || prev_if_ready) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end
      if (!mem_req || prev_mem_ready) begin
        mem_req   = ($urandom_range(0, 2) == 0);
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom_range(0, 15));
      end
      if_flush = ($urandom_range(0, 11) == 0);
      if (if_flush) if_addr = $urandom;
      rst = ($urandom_range(0, 249) == 0);
      prev_if_ready  = if_ready;
      prev_mem_ready = mem_ready;
      tick();
    end

    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0; resp_mode = 0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
